// File: rtl/rails_checker_pkg.sv
// rails_checker_pkg
//   Shared type definitions for the railway-station permutation checker.
//   state_t : checker FSM states
//   fail_t  : failure cause codes reported on fail_cause while valid is high
package rails_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_PUSH   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FAIL_NONE     = 2'd0,
        FAIL_ORDER    = 2'd1,
        FAIL_OVERFLOW = 2'd2,
        FAIL_RANGE    = 2'd3
    } fail_t;

endpackage

// File: rtl/rails_checker_stack.sv
// rails_checker_stack
//   LIFO holding the trains waiting in the station spur.
//   Ports:
//     clk       rising-edge clock
//     reset_n   asynchronous active-low reset, empties the stack
//     i_clear   synchronous empty, used when a new pattern header arrives
//     i_push    push i_data (ignored when full)
//     i_pop     discard the top entry (ignored when empty)
//     i_data    train number to push
//     o_top     train on top of the stack, 0 when empty
//     o_sp      number of trains currently held
//     o_full    stack holds DEPTH trains
module rails_checker_stack #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 15,
    localparam int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_top,
    output logic [SP_W-1:0]   o_sp,
    output logic              o_full
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [SP_W-1:0]   w_topIdx;

    assign w_topIdx = r_sp - SP_W'(1);
    assign o_full   = (r_sp == SP_W'(DEPTH));
    assign o_sp     = r_sp;
    assign o_top    = (r_sp == '0) ? '0 : r_mem[w_topIdx];

    // Stack pointer; clear wins so a new pattern always starts with an empty spur.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sp <= '0;
        end else if (i_clear) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (i_pop && (r_sp != '0)) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // Storage needs no reset: entries above the pointer are never read.
    always_ff @(posedge clk) begin
        if (!i_clear && i_push && !o_full) begin
            r_mem[r_sp] <= i_data;
        end
    end

endmodule

// File: rtl/rails_checker.sv
// rails_checker
//   Streaming checker deciding whether a departure order of trains 1..N is
//   achievable through a LIFO station spur of bounded capacity.
//   Ports:
//     clk         rising-edge clock
//     reset_n     asynchronous active-low reset
//     in_valid    beat qualifier
//     in_ready    beat accepted when in_valid & in_ready (IDLE or FETCH)
//     data        first beat = header N, then N train numbers
//     valid       one-cycle result strobe
//     result      1 = order achievable (while valid)
//     fail_cause  0 NONE, 1 ORDER, 2 OVERFLOW, 3 RANGE (while valid)
module rails_checker
    import rails_checker_pkg::*;
#(
    parameter int DATA_W      = 4,
    parameter int MAX_N       = 15,
    parameter int STACK_DEPTH = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              result,
    output logic [1:0]        fail_cause
);

    // Counters are one bit wider so next_in can reach N+1 without wrapping.
    localparam int CNT_W = DATA_W + 1;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);

    state_t            r_state;
    state_t            w_stateNext;
    logic [DATA_W-1:0] r_n;
    logic [DATA_W-1:0] r_tgt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_nextIn;
    fail_t             r_cause;

    logic              w_beat;
    logic              w_failed;
    logic [CNT_W-1:0]  w_t;
    logic [CNT_W-1:0]  w_nLimit;
    logic              w_headerRange;
    logic              w_tRange;
    logic              w_tPass;
    logic              w_tAhead;
    logic              w_topHit;
    logic              w_lastBeat;
    logic              w_pushMore;
    logic              w_fetchLive;
    logic              w_fetchPush;
    logic              w_clear;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_top;
    logic [SP_W-1:0]   w_sp;
    logic              w_full;

    assign w_beat        = in_valid && in_ready;
    assign w_failed      = (r_cause != FAIL_NONE);
    assign w_t           = {1'b0, data};
    assign w_nLimit      = {1'b0, r_n};
    assign w_headerRange = (w_t > CNT_W'(MAX_N));
    assign w_tRange      = (data == '0) || (w_t > w_nLimit);
    assign w_tPass       = (w_t == r_nextIn);
    assign w_tAhead      = (w_t > r_nextIn);
    assign w_topHit      = (w_sp != '0) && (w_top == data);
    assign w_lastBeat    = ((r_cnt + CNT_W'(1)) == w_nLimit);
    assign w_pushMore    = (r_nextIn < {1'b0, r_tgt});

    // A live FETCH beat is one that still influences the verdict; after the
    // first failure the remaining beats are only counted and dropped.
    assign w_fetchLive = (r_state == ST_FETCH) && w_beat && !w_failed && !w_tRange && !w_tPass;
    assign w_fetchPush = w_fetchLive && w_tAhead;

    assign w_clear = (r_state == ST_IDLE) && w_beat;
    assign w_push  = (r_state == ST_PUSH) && w_pushMore && !w_full;
    assign w_pop   = w_fetchLive && !w_tAhead && w_topHit;

    rails_checker_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_nextIn[DATA_W-1:0]),
        .o_top   (w_top),
        .o_sp    (w_sp),
        .o_full  (w_full)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state. PUSH leaves when the target train passes through or the
    // spur overflows; it returns to REPORT if that target was the last beat.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_beat) begin
                    w_stateNext = (data == '0) ? ST_REPORT : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_beat) begin
                    if (w_fetchPush) begin
                        w_stateNext = ST_PUSH;
                    end else if (w_lastBeat) begin
                        w_stateNext = ST_REPORT;
                    end
                end
            end
            ST_PUSH: begin
                if (!w_pushMore || w_full) begin
                    w_stateNext = (r_cnt == w_nLimit) ? ST_REPORT : ST_FETCH;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Pattern bookkeeping: header, beat count, next train to enter, PUSH
    // target and the first failure cause seen in this pattern.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n      <= '0;
            r_tgt    <= '0;
            r_cnt    <= '0;
            r_nextIn <= CNT_W'(1);
            r_cause  <= FAIL_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_beat) begin
                        r_n      <= data;
                        r_cnt    <= '0;
                        r_nextIn <= CNT_W'(1);
                        r_cause  <= w_headerRange ? FAIL_RANGE : FAIL_NONE;
                    end
                end
                ST_FETCH: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (!w_failed) begin
                            if (w_tRange) begin
                                r_cause <= FAIL_RANGE;
                            end else if (w_tPass) begin
                                r_nextIn <= r_nextIn + CNT_W'(1);
                            end else if (w_tAhead) begin
                                r_tgt <= data;
                            end else if (!w_topHit) begin
                                r_cause <= FAIL_ORDER;
                            end
                        end
                    end
                end
                ST_PUSH: begin
                    if (w_pushMore && w_full) begin
                        r_cause <= FAIL_OVERFLOW;
                    end else begin
                        r_nextIn <= r_nextIn + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are pure decodes of the current state.
    always_comb begin
        in_ready   = (r_state == ST_IDLE) || (r_state == ST_FETCH);
        valid      = (r_state == ST_REPORT);
        result     = (r_state == ST_REPORT) && (r_cause == FAIL_NONE);
        fail_cause = (r_state == ST_REPORT) ? r_cause : FAIL_NONE;
    end

endmodule
